spart_ctrl: RTL and testbench
=============================

Name: spart_ctrl

Overview:
Processor-side controller for the SPART serial port. Decodes the 2-bit I/O address bus, owns the 16-bit baud divisor and generates the 16x-oversample enable tick for the receiver and transmitter. Sequences transmit requests through a small handshake FSM and buffers received bytes with a ready-for-read flag. Sits between the processor bus and the RX/TX shift engines.

Parameters:
DEFAULT_DIV, 16'd162, divisor loaded at reset (50 MHz / (19200 baud x 16))
DIV_W, 16, divisor and baud counter width

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
iocs  input  1  chip select
iorw  input  1  1 = processor read, 0 = processor write
ioaddr  input  2  00 data, 01 status, 10 divisor low, 11 divisor high
data_in  input  8  processor write data
data_out  output  8  processor read data (combinational)
data_oe  output  1  read-drive enable = iocs & iorw
baud_en  output  1  one-cycle 16x sample tick to RX/TX
rx_valid  input  1  one-cycle pulse from receiver: rx_byte is a complete frame
rx_byte  input  8  received byte
tx_start  output  1  one-cycle pulse: TX begins sending tx_byte
tx_byte  output  8  byte held for the transmitter
tx_busy  input  1  transmitter shifting
rda  output  1  receive data available
tbr  output  1  transmit buffer ready

Behaviour:
- Reset (sync): divisor=DEFAULT_DIV, baud counter=DEFAULT_DIV, baud_en=0, rx_buf=0, rda=0, tx_byte=0, tx_start=0, TX FSM=IDLE (tbr=1), ovr=0.
- Bus access is a single-cycle strobe: read = iocs&iorw, write = iocs&~iorw, sampled each posedge.
- Reads: addr00 -> rx_buf; 01 -> {5'b0, ovr, rda, tbr}; 10 -> div[7:0]; 11 -> div[15:8]. data_out = 0 when data_oe = 0.
- Writes: 00 -> transmit request (see TX FSM); 01 -> ignored; 10 -> div[7:0] only, counter untouched; 11 -> div[15:8] and counter reloaded with {data_in, div[7:0]} the same cycle, baud_en=0 that cycle.
- Baud generator: down-counter; at 0 -> baud_en=1 for one cycle and reload with div; otherwise decrement. Tick period = div+1 cycles. div=0 -> baud_en held 0, counter held 0.
- RX buffer: rx_valid -> rx_buf<=rx_byte, rda<=1 next edge. Data read (addr00) clears rda. rx_valid and data read in same cycle: read returns old rx_buf, new byte captured, rda stays 1.
- TX FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  IDLE: tbr=1; data write -> tx_byte<=data_in, go START.
  START: tx_start=1 for exactly one cycle, go WAIT_BUSY.
  WAIT_BUSY: wait tx_busy=1 -> WAIT_DONE.
  WAIT_DONE: wait tx_busy=0 -> IDLE.
  tbr=0 in all non-IDLE states; data writes while tbr=0 are dropped, tx_byte unchanged.
- Reset mid-transmit or mid-receive: FSM to IDLE, tx_start deasserted, rda cleared at that edge regardless of other inputs.

Optional Feature:
SPART_OVERRUN_EN: defined -> ovr sets when rx_valid arrives while rda=1 (byte still overwritten), sticky, cleared by status read (addr01); rx_valid and status read in same cycle -> ovr=1. Undefined -> ovr logic absent, status bit2 reads 0.

Test Plan:
- Reset then read addr10/11 -> 8'hA2/8'h00; with no writes baud_en pulses every 163 cycles.
- Write addr10=8'h03, addr11=8'h00 -> first baud_en 4 cycles after the high write, then every 4 cycles; write div=0 -> baud_en stays 0.
- Pulse rx_valid with rx_byte=8'h5A -> status reads 8'h03; data read returns 8'h5A; next status read 8'h01.
- Write data 8'hC3 -> tx_start one pulse, tx_byte=8'hC3, tbr=0; second write 8'h11 while busy dropped; tx_busy 1 then 0 -> tbr=1, tx_byte still 8'hC3.
- With SPART_OVERRUN_EN: two rx_valid (8'h01, 8'h02) without read -> status 8'h07, data reads 8'h02; status read then clears ovr -> 8'h03.
- Assert rst in WAIT_DONE with rda=1 -> next cycle tbr=1, rda=0, tx_start=0, div=DEFAULT_DIV.

Source files
------------

// File: rtl/spart_ctrl.sv
// spart_ctrl: SPART processor-side bus decode, baud tick generator, RX buffer and TX handshake FSM.
// Define SPART_OVERRUN_EN to add the sticky receive-overrun status bit (status bit 2).
module spart_ctrl #(
    parameter int DIV_W = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       baud_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic       rda,
    output logic       tbr
);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;
    tx_state_t state, state_nxt;
    logic [DIV_W-1:0] div, cnt;
    logic [7:0] rx_buf;
    logic rd, wr, ovr;

    assign rd = iocs & iorw;
    assign wr = iocs & ~iorw;
    assign data_oe = rd;
    assign tbr = state == IDLE;

    // A high-byte write commits the full divisor and restarts the tick period from it
    always_ff @(posedge clk)
        if (rst) begin
            div <= DEFAULT_DIV;
            cnt <= DEFAULT_DIV;
            baud_en <= 1'b0;
        end else if (wr && ioaddr == 2'b11) begin
            div[DIV_W-1:8] <= data_in;
            cnt <= DIV_W'({data_in, div[7:0]});
            baud_en <= 1'b0;
        end else begin
            if (wr && ioaddr == 2'b10) div[7:0] <= data_in;
            baud_en <= div != '0 && cnt == '0;
            cnt <= div == '0 ? '0 : cnt == '0 ? div : cnt - DIV_W'(1);
        end

    always_ff @(posedge clk)
        if (rst) begin
            rx_buf <= '0;
            rda <= 1'b0;
        end else if (rx_valid) begin
            rx_buf <= rx_byte;
            rda <= 1'b1;
        end else if (rd && ioaddr == 2'b00) begin
            rda <= 1'b0;
        end

`ifdef SPART_OVERRUN_EN
    always_ff @(posedge clk)
        if (rst) ovr <= 1'b0;
        else if (rx_valid && rda) ovr <= 1'b1;
        else if (rd && ioaddr == 2'b01) ovr <= 1'b0;
`else
    assign ovr = 1'b0;
`endif

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            tx_byte <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && wr && ioaddr == 2'b00) tx_byte <= data_in;
        end

    always_comb begin
        state_nxt = state;
        tx_start = 1'b0;
        case (state)
            IDLE:      if (wr && ioaddr == 2'b00) state_nxt = START;
            START: begin
                tx_start = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
            default:   if (!tx_busy) state_nxt = IDLE;
        endcase
    end

    always_comb
        data_out = !rd ? 8'h00 :
                   ioaddr == 2'b00 ? rx_buf :
                   ioaddr == 2'b01 ? {5'b0, ovr, rda, tbr} :
                   ioaddr == 2'b10 ? div[7:0] : div[DIV_W-1:8];
endmodule

// File: tb/tb_spart_ctrl.sv
// tb_spart_ctrl: directed and randomized checks of spart_ctrl against an event-level reference model.
`timescale 1ns/1ps
module tb_spart_ctrl;
    localparam logic [15:0] DEF = 16'd162;
`ifdef SPART_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif
    logic clk = 0, rst = 1, iocs = 0, iorw = 0, rx_valid = 0, tx_busy = 0;
    logic [1:0] ioaddr = 0;
    logic [7:0] data_in = 0, rx_byte = 0;
    logic [7:0] data_out, tx_byte;
    logic data_oe, baud_en, tx_start, rda, tbr;
    int vecs = 0, errs = 0;

    spart_ctrl dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .baud_en(baud_en),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_start(tx_start), .tx_byte(tx_byte),
        .tx_busy(tx_busy), .rda(rda), .tbr(tbr)
    );

    always #5 clk = ~clk;

    // Reference model: baud ticks are predicted as absolute edge numbers, not a counter
    int cyc = 0, due = 0, m_ph = 0;
    logic [15:0] m_div = DEF;
    logic [7:0] m_buf = 0, m_txb = 0;
    logic m_rda = 0, m_ovr = 0, m_tick = 0, m_wr, m_rd;
    always @(posedge clk) begin
        m_wr = iocs & ~iorw;
        m_rd = iocs & iorw;
        cyc++;
        m_tick = 0;
        if (rst) begin
            m_div = DEF; due = cyc + DEF + 1; m_buf = 0; m_rda = 0; m_ovr = 0; m_txb = 0; m_ph = 0;
        end else begin
            if (m_wr && ioaddr == 3) begin
                m_div[15:8] = data_in;
                due = cyc + m_div + 1;
            end else begin
                if (m_div == 0) due = cyc + 1;
                else if (cyc == due) begin m_tick = 1; due = cyc + m_div + 1; end
                if (m_wr && ioaddr == 2) m_div[7:0] = data_in;
            end
            if (OVR_EN && rx_valid && m_rda) m_ovr = 1;
            else if (m_rd && ioaddr == 1) m_ovr = 0;
            if (rx_valid) begin m_buf = rx_byte; m_rda = 1; end
            else if (m_rd && ioaddr == 0) m_rda = 0;
            case (m_ph)
                0: if (m_wr && ioaddr == 0) begin m_txb = data_in; m_ph = 1; end
                1: m_ph = 2;
                2: if (tx_busy) m_ph = 3;
                default: if (!tx_busy) m_ph = 0;
            endcase
        end
    end

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
        return a == 0 ? m_buf : a == 1 ? {5'b0, m_ovr, m_rda, m_ph == 0} :
               a == 2 ? m_div[7:0] : m_div[15:8];
    endfunction

    task automatic clk1; @(posedge clk); #1; endtask
    task automatic bus(input logic rw, input logic [1:0] a, input logic [7:0] d);
        iocs = 1; iorw = rw; ioaddr = a; data_in = d;
    endtask
    task automatic idle; iocs = 0; iorw = 0; endtask

    task automatic test_reset;
        int t0, gap;
        rst = 1; clk1; clk1; rst = 0;
        vecs++; if (tbr !== 1 || rda !== 0 || tx_start !== 0 || baud_en !== 0 || tx_byte !== 0) begin
            errs++; $display("FAIL reset_flags: got tbr=%b rda=%b tx_start=%b baud_en=%b tx_byte=%h, want 1 0 0 0 00", tbr, rda, tx_start, baud_en, tx_byte); end
        bus(1, 2, 0); #1;
        vecs++; if (data_out !== 8'hA2 || data_oe !== 1) begin errs++; $display("FAIL reset_div_lo: got %h oe=%b, want a2 oe=1", data_out, data_oe); end
        clk1; bus(1, 3, 0); #1;
        vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_div_hi: got %h, want 00", data_out); end
        clk1; idle; #1;
        vecs++; if (data_out !== 8'h00 || data_oe !== 0) begin errs++; $display("FAIL no_oe_zero: got %h oe=%b, want 00 oe=0", data_out, data_oe); end
        t0 = -1; gap = 0;
        for (int i = 0; i < 400 && gap == 0; i++) begin
            clk1;
            if (baud_en) begin if (t0 < 0) t0 = cyc; else gap = cyc - t0; end
        end
        vecs++; if (gap !== 163) begin errs++; $display("FAIL default_period: got %0d, want 163", gap); end
    endtask

    task automatic test_baud;
        int n, seen;
        bus(0, 2, 8'h03); clk1; bus(0, 3, 8'h00); clk1; idle;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            for (int i = 1; i <= 20 && n == 0; i++) begin clk1; if (baud_en) n = i; end
            vecs++; if (n !== 4) begin errs++; $display("FAIL div3_interval%0d: got %0d, want 4", k, n); end
        end
        bus(0, 2, 8'h00); clk1; idle;
        seen = 0;
        repeat (40) begin clk1; seen += int'(baud_en); end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL div0_ticks: got %0d, want 0", seen); end
        bus(0, 2, 8'h05); clk1; idle;
    endtask

    task automatic test_rx;
        rx_byte = 8'h5A; rx_valid = 1; clk1; rx_valid = 0;
        bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h03) begin errs++; $display("FAIL rx_status1: got %h, want 03", data_out); end
        clk1; bus(1, 0, 0); #1;
        vecs++; if (data_out !== 8'h5A) begin errs++; $display("FAIL rx_data: got %h, want 5a", data_out); end
        clk1; bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h01) begin errs++; $display("FAIL rx_status2: got %h, want 01", data_out); end
        clk1;
        rx_byte = 8'hB7; rx_valid = 1; bus(1, 0, 0); #1;
        vecs++; if (data_out !== 8'h5A) begin errs++; $display("FAIL rx_same_cycle_old: got %h, want 5a", data_out); end
        clk1; rx_valid = 0; idle;
        vecs++; if (rda !== 1) begin errs++; $display("FAIL rx_same_cycle_rda: got %b, want 1", rda); end
        bus(1, 0, 0); #1;
        vecs++; if (data_out !== 8'hB7) begin errs++; $display("FAIL rx_same_cycle_new: got %h, want b7", data_out); end
        clk1; idle;
        vecs++; if (rda !== 0) begin errs++; $display("FAIL rx_rda_clear: got %b, want 0", rda); end
    endtask

    task automatic test_tx;
        bus(0, 0, 8'hC3); clk1; idle;
        vecs++; if (tx_start !== 1 || tx_byte !== 8'hC3 || tbr !== 0) begin
            errs++; $display("FAIL tx_start: got start=%b byte=%h tbr=%b, want 1 c3 0", tx_start, tx_byte, tbr); end
        clk1;
        vecs++; if (tx_start !== 0) begin errs++; $display("FAIL tx_start_width: got %b, want 0", tx_start); end
        bus(0, 0, 8'h11); clk1; idle;
        vecs++; if (tx_byte !== 8'hC3 || tbr !== 0 || tx_start !== 0) begin
            errs++; $display("FAIL tx_drop: got byte=%h tbr=%b start=%b, want c3 0 0", tx_byte, tbr, tx_start); end
        tx_busy = 1; repeat (4) clk1;
        vecs++; if (tbr !== 0) begin errs++; $display("FAIL tx_busy_tbr: got %b, want 0", tbr); end
        tx_busy = 0; clk1;
        vecs++; if (tbr !== 1 || tx_byte !== 8'hC3) begin errs++; $display("FAIL tx_done: got tbr=%b byte=%h, want 1 c3", tbr, tx_byte); end
    endtask

`ifdef SPART_OVERRUN_EN
    task automatic test_overrun;
        rx_byte = 8'h01; rx_valid = 1; clk1; rx_byte = 8'h02; clk1; rx_valid = 0;
        bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h07) begin errs++; $display("FAIL ovr_status: got %h, want 07", data_out); end
        clk1; bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h03) begin errs++; $display("FAIL ovr_cleared: got %h, want 03", data_out); end
        clk1; bus(1, 0, 0); #1;
        vecs++; if (data_out !== 8'h02) begin errs++; $display("FAIL ovr_data: got %h, want 02", data_out); end
        clk1; idle;
        rx_byte = 8'h33; rx_valid = 1; clk1;
        rx_byte = 8'h44; bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h03) begin errs++; $display("FAIL ovr_race_old: got %h, want 03", data_out); end
        clk1; rx_valid = 0; bus(1, 1, 0); #1;
        vecs++; if (data_out !== 8'h07) begin errs++; $display("FAIL ovr_race_set: got %h, want 07", data_out); end
        clk1; bus(1, 0, 0); clk1; idle;
    endtask
`endif

    task automatic test_reset_mid;
        bus(0, 0, 8'h9C); clk1; idle; clk1; tx_busy = 1; clk1;
        rx_byte = 8'h66; rx_valid = 1; clk1; rx_valid = 0;
        bus(0, 2, 8'h07); clk1; idle;
        vecs++; if (tbr !== 0 || rda !== 1) begin errs++; $display("FAIL mid_precond: got tbr=%b rda=%b, want 0 1", tbr, rda); end
        rst = 1; rx_valid = 1; bus(0, 0, 8'h55); clk1;
        vecs++; if (tbr !== 1 || rda !== 0 || tx_start !== 0 || tx_byte !== 8'h00) begin
            errs++; $display("FAIL mid_reset: got tbr=%b rda=%b start=%b byte=%h, want 1 0 0 00", tbr, rda, tx_start, tx_byte); end
        rst = 0; rx_valid = 0; tx_busy = 0; bus(1, 2, 0); #1;
        vecs++; if (data_out !== 8'hA2) begin errs++; $display("FAIL mid_div_lo: got %h, want a2", data_out); end
        clk1; bus(1, 3, 0); #1;
        vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL mid_div_hi: got %h, want 00", data_out); end
        clk1; idle;
    endtask

    task automatic test_random;
        logic [7:0] want;
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 149) == 0;
            iocs = $urandom_range(0, 2) == 0;
            iorw = 1'($urandom);
            ioaddr = 2'($urandom);
            data_in = ioaddr == 3 ? 8'h00 : ioaddr == 2 ? 8'($urandom_range(0, 6)) : 8'($urandom);
            rx_valid = $urandom_range(0, 5) == 0;
            rx_byte = 8'($urandom);
            if ($urandom_range(0, 3) == 0) tx_busy = ~tx_busy;
            #1;
            want = iocs && iorw ? exp_rd(ioaddr) : 8'h00;
            vecs++; if (data_out !== want || data_oe !== (iocs & iorw)) begin
                errs++; $display("FAIL rand_read[%0d]: got %h oe=%b, want %h oe=%b", i, data_out, data_oe, want, iocs & iorw); end
            clk1;
            vecs++; if (baud_en !== m_tick || tbr !== (m_ph == 0) || tx_start !== (m_ph == 1) || rda !== m_rda || tx_byte !== m_txb) begin
                errs++; $display("FAIL rand_state[%0d]: got baud=%b tbr=%b start=%b rda=%b byte=%h, want %b %b %b %b %h",
                    i, baud_en, tbr, tx_start, rda, tx_byte, m_tick, m_ph == 0, m_ph == 1, m_rda, m_txb); end
        end
        rst = 0; idle; rx_valid = 0; tx_busy = 0;
    endtask

    initial begin
        test_reset;
        test_baud;
        test_rx;
        test_tx;
`ifdef SPART_OVERRUN_EN
        test_overrun;
`endif
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
